// File: rtl/dcf77_frame_decoder.sv
// DCF77 minute-frame decoder: measures carrier-drop pulse widths in 10 ms ticks,
// locks onto the minute marker and assembles the 59 time bits of each minute.
module dcf77_frame_decoder #(
    parameter int TICK_DIV = 500000,
    parameter int ZERO_MIN = 5,
    parameter int ONE_MIN  = 15,
    parameter int ONE_MAX  = 25,
    parameter int MARK_MIN = 150,
    parameter int LOSS_MAX = 250
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        dcf_in,
    output logic [58:0] frame_data_out,
    output logic        frame_valid_out,
    output logic        bit_valid_out,
    output logic        bit_value_out,
    output logic [5:0]  bit_index_out,
    output logic        sync_out,
    output logic        error_out
);

    localparam int              PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST  = PW'(TICK_DIV - 1);
    localparam logic [7:0]      ZERO_MIN_C  = 8'(ZERO_MIN);
    localparam logic [7:0]      ONE_MIN_C   = 8'(ONE_MIN);
    localparam logic [7:0]      ONE_MAX_C   = 8'(ONE_MAX);
    localparam logic [7:0]      MARK_MIN_C  = 8'(MARK_MIN);
    localparam logic [7:0]      LOSS_MAX_C  = 8'(LOSS_MAX);
    localparam logic [5:0]      LAST_IDX    = 6'd58;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        PULSE     = 2'd1,
        GAP       = 2'd2
    } state_t;

    logic          sync0_r;
    logic          sync1_r;
    logic          prev_r;
    logic [PW-1:0] presc_r;
    logic [7:0]    width_r;
    state_t        state_r;
    logic [5:0]    idx_r;
    logic [58:0]   shadow_r;

    logic          rise_s;
    logic          fall_s;
    logic          edge_s;
    logic          tick_s;
    logic [7:0]    width_eff_s;
    logic          is_zero_s;
    logic          is_one_s;
    logic          is_mark_s;
    logic          too_long_s;
    logic          loss_s;

    // Two-flop synchronizer plus the delay flop used for edge detection.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync0_r <= 1'b0;
            sync1_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync0_r <= dcf_in;
            sync1_r <= sync0_r;
            prev_r  <= sync1_r;
        end
    end

    // Edge, tick and width classification; width_eff_s includes a tick landing this cycle.
    always_comb begin
        rise_s = sync1_r & ~prev_r;
        fall_s = ~sync1_r & prev_r;
        edge_s = rise_s | fall_s;
        tick_s = (presc_r == PRESC_LAST);
        if (tick_s && (width_r != 8'hFF)) begin
            width_eff_s = width_r + 8'd1;
        end else begin
            width_eff_s = width_r;
        end
        is_zero_s  = (width_eff_s >= ZERO_MIN_C) && (width_eff_s < ONE_MIN_C);
        is_one_s   = (width_eff_s >= ONE_MIN_C) && (width_eff_s <= ONE_MAX_C);
        is_mark_s  = (width_eff_s >= MARK_MIN_C);
        too_long_s = (width_eff_s > ONE_MAX_C);
        loss_s     = (width_eff_s >= LOSS_MAX_C);
    end

    // Tick prescaler and saturating width counter, both restarted on every edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            presc_r <= '0;
            width_r <= 8'd0;
        end else begin
            if (edge_s || tick_s) begin
                presc_r <= '0;
            end else begin
                presc_r <= presc_r + PW'(1);
            end
            if (edge_s) begin
                width_r <= 8'd0;
            end else begin
                width_r <= width_eff_s;
            end
        end
    end

    // Frame FSM with all outputs registered; strobes default low every cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r         <= WAIT_SYNC;
            idx_r           <= 6'd0;
            shadow_r        <= 59'd0;
            frame_data_out  <= 59'd0;
            frame_valid_out <= 1'b0;
            bit_valid_out   <= 1'b0;
            bit_value_out   <= 1'b0;
            bit_index_out   <= 6'd0;
            sync_out        <= 1'b0;
            error_out       <= 1'b0;
        end else begin
            frame_valid_out <= 1'b0;
            bit_valid_out   <= 1'b0;
            error_out       <= 1'b0;
            case (state_r)
                WAIT_SYNC: begin
                    sync_out <= 1'b0;
                    if (rise_s && is_mark_s) begin
                        idx_r    <= 6'd0;
                        sync_out <= 1'b1;
                        state_r  <= PULSE;
                    end
                end
                PULSE: begin
                    if (fall_s) begin
                        if (is_zero_s || is_one_s) begin
                            bit_valid_out    <= 1'b1;
                            bit_value_out    <= is_one_s;
                            bit_index_out    <= idx_r;
                            shadow_r[idx_r]  <= is_one_s;
                            state_r          <= GAP;
                        end else begin
                            error_out <= 1'b1;
                            sync_out  <= 1'b0;
                            state_r   <= WAIT_SYNC;
                        end
                    end else if (too_long_s) begin
                        error_out <= 1'b1;
                        sync_out  <= 1'b0;
                        state_r   <= WAIT_SYNC;
                    end
                end
                GAP: begin
                    if (rise_s) begin
                        if (is_mark_s) begin
                            // A marker always restarts the minute; only a full one publishes.
                            if (idx_r == LAST_IDX) begin
                                frame_data_out  <= shadow_r;
                                frame_valid_out <= 1'b1;
                            end else begin
                                error_out <= 1'b1;
                            end
                            idx_r   <= 6'd0;
                            state_r <= PULSE;
                        end else if (idx_r == LAST_IDX) begin
                            error_out <= 1'b1;
                            sync_out  <= 1'b0;
                            state_r   <= WAIT_SYNC;
                        end else begin
                            idx_r   <= idx_r + 6'd1;
                            state_r <= PULSE;
                        end
                    end else if (loss_s) begin
                        error_out <= 1'b1;
                        sync_out  <= 1'b0;
                        state_r   <= WAIT_SYNC;
                    end
                end
                default: begin
                    sync_out <= 1'b0;
                    state_r  <= WAIT_SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcf77_frame_decoder.sv
// Bench for dcf77_frame_decoder: tick-accurate DCF77 waveforms against a bit/frame reference model.
module tb_dcf77_frame_decoder;

    localparam int TD = 10;

    logic        clk_in;
    logic        rst_n_in;
    logic        dcf_in;
    logic [58:0] frame_data_out;
    logic        frame_valid_out;
    logic        bit_valid_out;
    logic        bit_value_out;
    logic [5:0]  bit_index_out;
    logic        sync_out;
    logic        error_out;

    dcf77_frame_decoder #(.TICK_DIV(TD)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .dcf_in          (dcf_in),
        .frame_data_out  (frame_data_out),
        .frame_valid_out (frame_valid_out),
        .bit_valid_out   (bit_valid_out),
        .bit_value_out   (bit_value_out),
        .bit_index_out   (bit_index_out),
        .sync_out        (sync_out),
        .error_out       (error_out)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fall_cyc = 0;
    int last_bit_cyc = 0;
    int last_err_cyc = 0;
    int err_cnt = 0;
    int frame_cnt = 0;
    int both_cnt = 0;
    logic [6:0]  obs_q[$];
    logic [6:0]  exp_q[$];
    logic [58:0] exp_frame;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc++;

    // Strobe monitor: records decoded bits and counts error/frame events.
    always @(negedge clk_in) begin
        if (bit_valid_out) begin
            obs_q.push_back({bit_index_out, bit_value_out});
            last_bit_cyc = cyc;
        end
        if (error_out) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
        if (frame_valid_out) frame_cnt++;
        if (error_out && frame_valid_out) both_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_strobes(input string tag);
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check(tag, 64'(obs_q[i]), 64'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    // Drive a level for a whole number of ticks, starting on a falling clock edge.
    task automatic hold(input logic lvl, input int ticks);
        @(negedge clk_in);
        if (dcf_in === 1'b1 && lvl == 1'b0) fall_cyc = cyc;
        dcf_in = lvl;
        repeat (ticks * TD - 1) @(negedge clk_in);
    endtask

    task automatic send_pulse(input int w, input int gap);
        hold(1'b1, w);
        hold(1'b0, gap);
    endtask

    function automatic int rand_width(input logic v);
        if (v) return $urandom_range(25, 15);
        return $urandom_range(14, 5);
    endfunction

    // Locked bit: the model expects a strobe with this index and value.
    task automatic send_locked(input int idx, input logic v, input int gap);
        exp_q.push_back({6'(idx), v});
        send_pulse(rand_width(v), gap);
    endtask

    initial begin
        int e0;
        int f0;
        logic v;
        dcf_in   = 1'b0;
        rst_n_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_frame", 64'(frame_data_out), 64'd0);
        check("rst_sync", 64'(sync_out), 64'd0);
        check("rst_strobes", 64'({frame_valid_out, bit_valid_out, bit_value_out, error_out}), 64'd0);
        check("rst_index", 64'(bit_index_out), 64'd0);
        rst_n_in = 1'b1;

        // Pulses with no preceding marker must stay silent.
        hold(1'b0, 5);
        for (int i = 0; i < 4; i++) send_pulse(rand_width(1'($urandom_range(1, 0))), 12);
        check("premark_sync", 64'(sync_out), 64'd0);
        check("premark_err", 64'(err_cnt), 64'd0);
        compare_strobes("premark_bits");

        // Full minute: alternating 10/20-tick pulses at 1 s spacing.
        hold(1'b0, 160);
        exp_frame = 59'd0;
        for (int i = 0; i < 59; i++) begin
            v = 1'(i % 2);
            exp_frame[i] = v;
            exp_q.push_back({6'(i), v});
            send_pulse(v ? 20 : 10, (i == 58) ? (200 - (v ? 20 : 10)) : (100 - (v ? 20 : 10)));
            if (i == 0) check("lock_sync", 64'(sync_out), 64'd1);
        end
        compare_strobes("frame_bits");
        e0 = err_cnt;
        f0 = frame_cnt;
        send_locked(0, 1'($urandom_range(1, 0)), $urandom_range(8, 3));
        check("frame_strobe", 64'(frame_cnt), 64'(f0 + 1));
        check("frame_data", 64'(frame_data_out), 64'(exp_frame));
        check("frame_noerr", 64'(err_cnt), 64'(e0));

        // Early marker after 40 bits: error, frame kept, still locked.
        for (int i = 1; i < 40; i++)
            send_locked(i, 1'($urandom_range(1, 0)), (i == 39) ? 170 : $urandom_range(8, 3));
        e0 = err_cnt;
        send_locked(0, 1'($urandom_range(1, 0)), $urandom_range(8, 3));
        check("early_err", 64'(err_cnt), 64'(e0 + 1));
        check("early_frame", 64'(frame_data_out), 64'(exp_frame));
        check("early_fcnt", 64'(frame_cnt), 64'(f0 + 1));
        check("early_sync", 64'(sync_out), 64'd1);

        // Reset during bit 30 of the new minute.
        for (int i = 1; i < 30; i++) send_locked(i, 1'($urandom_range(1, 0)), $urandom_range(8, 3));
        compare_strobes("relock_bits");
        hold(1'b1, 5);
        #2 rst_n_in = 1'b0;
        #1;
        check("arst_frame", 64'(frame_data_out), 64'd0);
        check("arst_sync", 64'(sync_out), 64'd0);
        check("arst_index", 64'(bit_index_out), 64'd0);
        check("arst_strobes", 64'({frame_valid_out, bit_valid_out, bit_value_out, error_out}), 64'd0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        hold(1'b1, 5);
        hold(1'b0, 10);
        for (int i = 0; i < 3; i++) send_pulse(rand_width(1'($urandom_range(1, 0))), 10);
        check("postrst_sync", 64'(sync_out), 64'd0);
        compare_strobes("postrst_bits");
        hold(1'b0, 160);
        send_locked(0, 1'($urandom_range(1, 0)), $urandom_range(8, 3));
        compare_strobes("remark_bits");
        check("bit_latency", 64'(last_bit_cyc - fall_cyc), 64'd3);

        // 3-tick pulse while locked.
        e0 = err_cnt;
        send_pulse(3, 10);
        check("short_err", 64'(err_cnt), 64'(e0 + 1));
        check("short_sync", 64'(sync_out), 64'd0);
        compare_strobes("short_bits");

        // Signal loss: low for 260 ticks after a locked bit.
        hold(1'b0, 160);
        exp_q.push_back({6'd0, 1'b1});
        hold(1'b1, 20);
        e0 = err_cnt;
        hold(1'b0, 260);
        check("loss_err", 64'(err_cnt), 64'(e0 + 1));
        check("loss_time", 64'(last_err_cyc - fall_cyc), 64'(3 + 250 * TD));
        check("loss_sync", 64'(sync_out), 64'd0);
        compare_strobes("loss_bits");
        check("err_frame_excl", 64'(both_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
